tlp_tx_scheduler: RTL and testbench
===================================

# tlp_tx_scheduler

Drains the ADC packer's header FIFO (40-bit) and data FIFO (64-bit) and emits PCIe 4DW Memory Write TLPs on a 64-bit valid/ready transmit stream. Each TLP carries one header entry plus `WORDS_PER_TLP` data words. Target addresses ping-pong between two host buffers selected by the buffer counter bit 0. Sits between the packer FIFOs and the PCIe core TX interface in the InputClock domain.

## Interface
- `WORDS_PER_TLP`, default 15: data words (64-bit) per TLP; 15 words = 120 bytes = 30 DW.
- `DCOUNT_W`, default 10: width of the data FIFO occupancy count.
- `InputClock` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `Enable` in 1: scheduler run; sampled only in IDLE.
- `BufBase0`, `BufBase1` in 64: host buffer base addresses; bits [1:0] are ignored.
- `BufferLengthTLPs` in 16: index of the last TLP in a buffer, same value the packer uses.
- `RequesterId` in 16: PCIe requester ID.
- `HdrEmpty` in 1: header FIFO empty.
- `HdrDout` in 40: FWFT header word. Fields: [39:24] buffer index, [23:8] TLP index, [7:5] flags.
- `HdrRd` out 1: header FIFO pop.
- `DataCount` in DCOUNT_W: data FIFO occupancy.
- `DataDout` in 64: FWFT data word.
- `DataRd` out 1: data FIFO pop.
- `TxData` out 64: stream beat.
- `TxValid` out 1: beat valid.
- `TxSop` out 1: first beat of a TLP.
- `TxEop` out 1: last beat of a TLP.
- `TxReady` in 1: sink accepts.
- `BufDone` out 1: one-cycle pulse when a buffer's last TLP completes.
- `BufDoneIdx` out 16: buffer index for BufDone.
- `TlpsSent` out 32: count of TLPs fully accepted.
- `Busy` out 1: state is not IDLE.

## Operation
- Beat transfer: a beat transfers when `TxValid && TxReady`. While `TxValid=1` and the beat is not accepted, `TxData`, `TxSop` and `TxEop` hold stable.
- States: IDLE → HDR0 → HDR1 → DATA → IDLE.
- IDLE → HDR0 when `Enable && !HdrEmpty && DataCount >= WORDS_PER_TLP`. On this transition, latch `HdrDout` and compute the address; `HdrRd` does not pulse here.
- HDR0 beat:
  - [63:32] = DW0 = {1'b0, 2'b11, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 10'd(2*WORDS_PER_TLP)}.
  - [31:0] = DW1 = {RequesterId, 3'b000, Tag[4:0], 4'hF, 4'hF}.
  - `TxSop=1`.
  - On transfer, `HdrRd` pulses for 1 cycle and the state goes to HDR1.
- HDR1 beat: {Addr[63:32], Addr[31:2], 2'b00}. On transfer, go to DATA.
- Address: Addr = (buf_idx[0] ? BufBase1 : BufBase0) + tli*120. tli is the TLP index, zero-extended to 64 bits. tli*120 is computed as (tli<<7) − (tli<<3). Arithmetic is 64-bit with wrap.
- DATA:
  - `TxData = DataDout`.
  - Each transfer pulses `DataRd` for 1 cycle and increments the word counter.
  - On the transfer of word `WORDS_PER_TLP−1`, `TxEop=1`, and the state returns to IDLE.
- On EOP transfer:
  - Tag increments mod 32.
  - `TlpsSent` increments, wrapping at 2^32.
  - If tli == `BufferLengthTLPs`: `BufDone` pulses the next cycle and `BufDoneIdx` takes the latched buf_idx.
- Enable deassert mid-TLP: the current TLP completes. Enable is only checked in IDLE.
- FIFO gating: the IDLE-entry condition guarantees data is present for the whole TLP. The data FIFO cannot underflow within a TLP.
- Reset values: state IDLE, `TxValid` 0, `TxSop` 0, `TxEop` 0, `TxData` 0, `HdrRd` 0, `DataRd` 0, `BufDone` 0, `BufDoneIdx` 0, `TlpsSent` 0, Tag 0, `Busy` 0. Reset mid-TLP abandons the partial TLP; FIFO contents are not touched.

## Timing
- `TxValid` is registered and rises the cycle after the IDLE→HDR0 decision.
- Minimum TLP length: 2 + WORDS_PER_TLP beats. With `TxReady` held at 1, beats are back-to-back.
- One idle cycle between TLPs (IDLE re-evaluation): 18 cycles per TLP for WORDS_PER_TLP=15.
- `HdrRd` and `DataRd` are combinational with the accepted beat, same cycle as the transfer. The FWFT word for the next beat is valid the following cycle.
- `BufDone` occurs 1 cycle after the EOP transfer. `Busy` is 0 in that same cycle.
- `TxReady` low on any beat stalls in place with no pop.

## Test plan
- Single TLP: BufBase0=64'h1000, header buf=0, tli=2, 15 data words 1..15, TxReady=1 → beats: DW0 length=30, tag 0; address 64'h10F0; data 1..15; Sop on beat 0, Eop on beat 16; HdrRd ×1, DataRd ×15; TlpsSent=1.
- Ping-pong plus buffer end: BufferLengthTLPs=3, buf=1, tli=3, BufBase1=64'h8000_0000 → Addr=64'h8000_0168; BufDone pulses with BufDoneIdx=1.
- Backpressure: TxReady toggles 0/1 every cycle → every beat is held stable while TxReady=0; no pops on stalled cycles; output data identical to the unstalled run.
- Gating: header present, DataCount=14 → stays IDLE, TxValid=0; DataCount goes to 15 → TLP starts next cycle.
- Enable drop at data word 5 → TLP completes with Eop; a second queued header is not started until Enable=1.
- Reset at HDR1 → all outputs take reset values next cycle; Tag=0; a later TLP restarts cleanly from HDR0.

Source files
------------

// File: rtl/tlp_tx_scheduler.sv
// tlp_tx_scheduler: drains the packer header/data FIFOs and emits 4DW Memory
// Write TLPs (two header beats plus WORDS_PER_TLP data beats) on a 64-bit
// valid/ready stream, ping-ponging between two host buffers.
module tlp_tx_scheduler #(
  parameter int unsigned WORDS_PER_TLP = 15,
  parameter int unsigned DCOUNT_W      = 10
) (
  input  logic                InputClock,
  input  logic                rst,
  input  logic                Enable,
  input  logic [63:0]         BufBase0,
  input  logic [63:0]         BufBase1,
  input  logic [15:0]         BufferLengthTLPs,
  input  logic [15:0]         RequesterId,
  input  logic                HdrEmpty,
  input  logic [39:0]         HdrDout,
  output logic                HdrRd,
  input  logic [DCOUNT_W-1:0] DataCount,
  input  logic [63:0]         DataDout,
  output logic                DataRd,
  output logic [63:0]         TxData,
  output logic                TxValid,
  output logic                TxSop,
  output logic                TxEop,
  input  logic                TxReady,
  output logic                BufDone,
  output logic [15:0]         BufDoneIdx,
  output logic [31:0]         TlpsSent,
  output logic                Busy
);

  localparam int unsigned CntW = (WORDS_PER_TLP > 1) ? $clog2(WORDS_PER_TLP) : 1;
  localparam logic [CntW-1:0]     LastWord  = CntW'(WORDS_PER_TLP - 1);
  localparam logic [DCOUNT_W-1:0] NeedWords = DCOUNT_W'(WORDS_PER_TLP);
  localparam logic [9:0]          LenDw     = 10'(2 * WORDS_PER_TLP);
  // MWr 4DW: fmt=3'b011, type=0, TC/attr/TD/EP all zero, length in DW.
  localparam logic [31:0]         Dw0 = {1'b0, 2'b11, 5'b00000, 1'b0, 3'b000, 4'b0000,
                                         1'b0, 1'b0, 2'b00, 2'b00, LenDw};

  typedef enum logic [1:0] {StIdle, StHdr0, StHdr1, StData} state_e;

  state_e          state_q;
  logic            tx_valid_q, tx_sop_q, tx_eop_q;
  logic [15:0]     buf_idx_q, tli_q;
  logic [63:2]     addr_q;
  logic [4:0]      tag_q;
  logic [CntW-1:0] cnt_q;
  logic            buf_done_q;
  logic [15:0]     buf_done_idx_q;
  logic [31:0]     tlps_q;

  logic            xfer, start_d;
  logic [63:0]     base_sel, tli_ext, addr_d;
  logic [CntW-1:0] cnt_d;
  logic [63:0]     tx_data;
  logic            unused_bits;

  // Transfer, start decision and target address for the header at the FIFO head.
  always_comb begin
    xfer     = tx_valid_q & TxReady;
    start_d  = (state_q == StIdle) & Enable & ~HdrEmpty & (DataCount >= NeedWords);
    base_sel = HdrDout[24] ? BufBase1 : BufBase0;
    tli_ext  = {48'd0, HdrDout[23:8]};
    // tli * 120 without a multiplier.
    addr_d   = base_sel + (tli_ext << 7) - (tli_ext << 3);
    cnt_d    = cnt_q + CntW'(1);
  end

  // Scheduler FSM with registered stream controls and status.
  always_ff @(posedge InputClock) begin
    if (rst) begin
      state_q        <= StIdle;
      tx_valid_q     <= 1'b0;
      tx_sop_q       <= 1'b0;
      tx_eop_q       <= 1'b0;
      buf_idx_q      <= '0;
      tli_q          <= '0;
      addr_q         <= '0;
      tag_q          <= '0;
      cnt_q          <= '0;
      buf_done_q     <= 1'b0;
      buf_done_idx_q <= '0;
      tlps_q         <= '0;
    end else begin
      buf_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_d) begin
            state_q    <= StHdr0;
            tx_valid_q <= 1'b1;
            tx_sop_q   <= 1'b1;
            tx_eop_q   <= 1'b0;
            buf_idx_q  <= HdrDout[39:24];
            tli_q      <= HdrDout[23:8];
            addr_q     <= addr_d[63:2];
          end
        end
        StHdr0: begin
          if (xfer) begin
            state_q  <= StHdr1;
            tx_sop_q <= 1'b0;
          end
        end
        StHdr1: begin
          if (xfer) begin
            state_q  <= StData;
            cnt_q    <= '0;
            tx_eop_q <= (LastWord == '0);
          end
        end
        StData: begin
          if (xfer) begin
            if (cnt_q == LastWord) begin
              state_q    <= StIdle;
              tx_valid_q <= 1'b0;
              tx_eop_q   <= 1'b0;
              tag_q      <= tag_q + 5'd1;
              tlps_q     <= tlps_q + 32'd1;
              if (tli_q == BufferLengthTLPs) begin
                buf_done_q     <= 1'b1;
                buf_done_idx_q <= buf_idx_q;
              end
            end else begin
              cnt_q    <= cnt_d;
              tx_eop_q <= (cnt_d == LastWord);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Beat payload follows the state; data beats pass the FWFT word straight through.
  always_comb begin
    tx_data = '0;
    case (state_q)
      StHdr0:  tx_data = {Dw0, RequesterId, 3'b000, tag_q, 4'hF, 4'hF};
      StHdr1:  tx_data = {addr_q, 2'b00};
      StData:  tx_data = DataDout;
      default: tx_data = '0;
    endcase
  end

  // FIFO pops coincide with the accepted beat.
  always_comb begin
    HdrRd  = xfer & (state_q == StHdr0);
    DataRd = xfer & (state_q == StData);
  end

  assign TxData      = tx_data;
  assign TxValid     = tx_valid_q;
  assign TxSop       = tx_sop_q;
  assign TxEop       = tx_eop_q;
  assign BufDone     = buf_done_q;
  assign BufDoneIdx  = buf_done_idx_q;
  assign TlpsSent    = tlps_q;
  assign Busy        = (state_q != StIdle);

  // Header flags and the low address bits are not needed.
  assign unused_bits = ^{HdrDout[7:0], addr_d[1:0]};

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// tb_tlp_tx_scheduler: directed bench with FIFO models and a beat scoreboard.
module tb_tlp_tx_scheduler;

  localparam int unsigned W  = 15;
  localparam int unsigned DW = 10;

  typedef struct packed {
    logic [1:0]  kind;     // 0 hdr0, 1 hdr1, 2 data
    logic        sop;
    logic        eop;
    logic        lastbuf;
    logic [15:0] bidx;
    logic [63:0] data;
  } beat_t;

  logic          InputClock;
  logic          rst;
  logic          Enable;
  logic [63:0]   BufBase0, BufBase1;
  logic [15:0]   BufferLengthTLPs, RequesterId;
  logic          HdrEmpty;
  logic [39:0]   HdrDout;
  logic          HdrRd;
  logic [DW-1:0] DataCount;
  logic [63:0]   DataDout;
  logic          DataRd;
  logic [63:0]   TxData;
  logic          TxValid, TxSop, TxEop, TxReady;
  logic          BufDone;
  logic [15:0]   BufDoneIdx;
  logic [31:0]   TlpsSent;
  logic          Busy;

  tlp_tx_scheduler #(.WORDS_PER_TLP(W), .DCOUNT_W(DW)) dut (
    .InputClock(InputClock), .rst(rst), .Enable(Enable),
    .BufBase0(BufBase0), .BufBase1(BufBase1),
    .BufferLengthTLPs(BufferLengthTLPs), .RequesterId(RequesterId),
    .HdrEmpty(HdrEmpty), .HdrDout(HdrDout), .HdrRd(HdrRd),
    .DataCount(DataCount), .DataDout(DataDout), .DataRd(DataRd),
    .TxData(TxData), .TxValid(TxValid), .TxSop(TxSop), .TxEop(TxEop),
    .TxReady(TxReady), .BufDone(BufDone), .BufDoneIdx(BufDoneIdx),
    .TlpsSent(TlpsSent), .Busy(Busy)
  );

  initial InputClock = 1'b0;
  always #5 InputClock = ~InputClock;

  beat_t       exp_q[$];
  logic [39:0] hq[$];
  logic [63:0] dq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          hdr_pops = 0;
  int          data_pops = 0;
  int          bd_count = 0;
  int          m_tlps = 0;
  logic        pend_hdr = 1'b0;
  logic        pend_data = 1'b0;
  logic        bd_chk = 1'b0;
  logic        bd_exp = 1'b0;
  logic [15:0] bd_idx = '0;
  logic [4:0]  m_tag = '0;
  logic        cur_last = 1'b0;
  logic [15:0] cur_bidx = '0;
  logic        ready_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %0h required %0h", tag, obs, want);
  endtask

  task automatic refresh();
    HdrEmpty  = (hq.size() == 0);
    HdrDout   = (hq.size() != 0) ? hq[0] : 40'd0;
    DataCount = DW'(dq.size());
    DataDout  = (dq.size() != 0) ? dq[0] : 64'd0;
  endtask

  task automatic push_hdr(input logic [15:0] b, input logic [15:0] t);
    logic [63:0] addr;
    beat_t bt;
    hq.push_back({b, t, 8'h00});
    addr = (b[0] ? BufBase1 : BufBase0) + 64'(t) * 64'd120;
    addr[1:0] = 2'b00;
    bt = '{kind: 2'd0, sop: 1'b1, eop: 1'b0, lastbuf: 1'b0, bidx: b,
           data: {32'h6000_0000 | 32'(2 * W), RequesterId, 3'b000, m_tag, 8'hFF}};
    exp_q.push_back(bt);
    bt = '{kind: 2'd1, sop: 1'b0, eop: 1'b0, lastbuf: 1'b0, bidx: b, data: addr};
    exp_q.push_back(bt);
    m_tag    = m_tag + 5'd1;
    cur_last = (t == BufferLengthTLPs);
    cur_bidx = b;
    refresh();
  endtask

  task automatic push_data(input logic [63:0] d, input logic last);
    beat_t bt;
    dq.push_back(d);
    bt = '{kind: 2'd2, sop: 1'b0, eop: last, lastbuf: last & cur_last, bidx: cur_bidx,
           data: d};
    exp_q.push_back(bt);
    if (last) m_tlps++;
    refresh();
  endtask

  task automatic push_tlp(input logic [15:0] b, input logic [15:0] t, input logic [63:0] first);
    push_hdr(b, t);
    for (int i = 0; i < int'(W); i++) push_data(first + 64'(i), i == int'(W) - 1);
  endtask

  task automatic wait_drain(input int max);
    int c = 0;
    while ((exp_q.size() != 0 || Busy) && c < max) begin
      @(posedge InputClock); #1;
      c++;
    end
    chk("drain_in_time", 64'(c < max), 64'd1);
    repeat (2) begin @(posedge InputClock); #1; end
  endtask

  // FIFO model: pops requested in a cycle take effect just after its clock edge.
  always @(posedge InputClock) begin
    #1;
    if (pend_hdr && hq.size() != 0) void'(hq.pop_front());
    if (pend_data && dq.size() != 0) void'(dq.pop_front());
    pend_hdr  = 1'b0;
    pend_data = 1'b0;
    refresh();
  end

  // Sink and monitor: drive TxReady for the coming edge, then score the beat.
  always @(negedge InputClock) begin
    beat_t e;
    TxReady = ready_mode ? ~TxReady : 1'b1;
    #1;
    if (BufDone) bd_count++;
    if (bd_chk) begin
      chk("bufdone", 64'(BufDone), 64'(bd_exp));
      if (bd_exp) chk("bufdone_idx", 64'(BufDoneIdx), 64'(bd_idx));
      chk("busy_after_eop", 64'(Busy), 64'd0);
      bd_chk = 1'b0;
    end
    if (TxValid) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("tx_data", TxData, e.data);
        chk("tx_sop", 64'(TxSop), 64'(e.sop));
        chk("tx_eop", 64'(TxEop), 64'(e.eop));
        chk("hdr_rd", 64'(HdrRd), 64'(TxReady && e.kind == 2'd0));
        chk("data_rd", 64'(DataRd), 64'(TxReady && e.kind == 2'd2));
        if (TxReady) begin
          void'(exp_q.pop_front());
          if (e.eop) begin
            bd_chk = 1'b1;
            bd_exp = e.lastbuf;
            bd_idx = e.bidx;
          end
        end
      end
    end else begin
      chk("no_pop_when_idle", 64'({HdrRd, DataRd}), 64'd0);
    end
    if (HdrRd) hdr_pops++;
    if (DataRd) data_pops++;
    pend_hdr  = pend_hdr | HdrRd;
    pend_data = pend_data | DataRd;
  end

  initial begin
    int h0, d0, b0, c;
    rst = 1'b1; Enable = 1'b0; TxReady = 1'b1;
    BufBase0 = 64'h1000; BufBase1 = 64'h8000_0000;
    BufferLengthTLPs = 16'd100; RequesterId = 16'hABCD;
    refresh();
    repeat (3) begin @(posedge InputClock); #1; end
    chk("rst_valid", 64'(TxValid), 0); chk("rst_sop", 64'(TxSop), 0);
    chk("rst_eop", 64'(TxEop), 0);     chk("rst_data", TxData, 0);
    chk("rst_busy", 64'(Busy), 0);     chk("rst_tlps", 64'(TlpsSent), 0);
    chk("rst_bufdone", 64'(BufDone), 0);
    rst = 1'b0;

    // Single TLP, buffer 0, tli 2 -> 0x10F0.
    h0 = hdr_pops; d0 = data_pops;
    push_tlp(16'd0, 16'd2, 64'd1);
    Enable = 1'b1;
    wait_drain(100);
    chk("t1_tlps", 64'(TlpsSent), 64'(m_tlps));
    chk("t1_hdr_pops", 64'(hdr_pops - h0), 1);
    chk("t1_data_pops", 64'(data_pops - d0), 15);

    // Ping-pong to buffer 1 and buffer end.
    BufferLengthTLPs = 16'd3; b0 = bd_count;
    push_tlp(16'd1, 16'd3, 64'h5000);
    wait_drain(100);
    chk("t2_bufdone_pulses", 64'(bd_count - b0), 1);
    BufferLengthTLPs = 16'd100;

    // Backpressure: same payload as the first TLP with TxReady toggling.
    ready_mode = 1'b1; h0 = hdr_pops; d0 = data_pops;
    push_tlp(16'd0, 16'd2, 64'd1);
    wait_drain(200);
    ready_mode = 1'b0;
    chk("t3_hdr_pops", 64'(hdr_pops - h0), 1);
    chk("t3_data_pops", 64'(data_pops - d0), 15);
    chk("t3_tlps", 64'(TlpsSent), 64'(m_tlps));

    // Gating on data occupancy.
    push_hdr(16'd1, 16'd4);
    for (int i = 0; i < int'(W) - 1; i++) push_data(64'hA0 + 64'(i), 1'b0);
    repeat (5) begin @(posedge InputClock); #1; end
    chk("t4_gated_valid", 64'(TxValid), 0);
    chk("t4_gated_busy", 64'(Busy), 0);
    push_data(64'hA0 + 64'(W - 1), 1'b1);
    @(posedge InputClock); #1;
    chk("t4_start_valid", 64'(TxValid), 1);
    chk("t4_start_sop", 64'(TxSop), 1);
    wait_drain(100);

    // Enable drop mid-TLP with a second TLP queued.
    push_tlp(16'd0, 16'd6, 64'h100);
    push_tlp(16'd1, 16'd7, 64'h200);
    d0 = data_pops; c = 0;
    while (data_pops < d0 + 5 && c < 100) begin @(posedge InputClock); #1; c++; end
    chk("t5_reach_word5", 64'(c < 100), 1);
    Enable = 1'b0;
    c = 0;
    while ((Busy || exp_q.size() > 17) && c < 100) begin @(posedge InputClock); #1; c++; end
    repeat (5) begin @(posedge InputClock); #1; end
    chk("t5_held_busy", 64'(Busy), 0);
    chk("t5_held_valid", 64'(TxValid), 0);
    chk("t5_pending_beats", 64'(exp_q.size()), 17);
    chk("t5_hdr_waiting", 64'(HdrEmpty), 0);
    Enable = 1'b1;
    wait_drain(100);
    chk("t5_tlps", 64'(TlpsSent), 64'(m_tlps));

    // Reset while the address beat is on the bus.
    h0 = hdr_pops;
    push_tlp(16'd0, 16'd9, 64'h300);
    c = 0;
    while (hdr_pops == h0 && c < 100) begin @(posedge InputClock); #1; c++; end
    chk("t6_in_hdr1", 64'(TxValid && !TxSop), 1);
    rst = 1'b1;
    @(posedge InputClock); #1;
    chk("t6_valid", 64'(TxValid), 0);   chk("t6_sop", 64'(TxSop), 0);
    chk("t6_eop", 64'(TxEop), 0);       chk("t6_data", TxData, 0);
    chk("t6_rd", 64'({HdrRd, DataRd}), 0);
    chk("t6_bufdone", 64'(BufDone), 0); chk("t6_bufdone_idx", 64'(BufDoneIdx), 0);
    chk("t6_tlps", 64'(TlpsSent), 0);   chk("t6_busy", 64'(Busy), 0);
    hq.delete(); dq.delete(); exp_q.delete();
    m_tag = '0; m_tlps = 0;
    refresh();
    @(posedge InputClock); #1;
    rst = 1'b0;
    push_tlp(16'd1, 16'd5, 64'h400);
    wait_drain(100);
    chk("t6_restart_tlps", 64'(TlpsSent), 64'(m_tlps));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
